// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target for the pipeline's memory stage.
// Accepts one load/store at a time, holds it for LATENCY cycles, performs the
// word access on the edge that enters RESP and returns a single-cycle response.
// The stall output keeps the pipeline frozen while an access is outstanding.
module dmem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_byte_en,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        stall
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam bit SINGLE_CYCLE = (LATENCY == 1);
  // WAIT lasts LATENCY-1 cycles, so the counter starts at LATENCY-2.
  localparam int CNT_INIT_I = (LATENCY > 1) ? (LATENCY - 2) : 0;
  localparam logic [3:0] CNT_INIT = CNT_INIT_I[3:0];

  state_t      state;
  logic [3:0]  wait_cnt;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_byte_en;

  logic [31:0] mem [0:DEPTH-1];

  logic                  accept;
  logic                  enter_resp;
  logic                  cur_write;
  logic [31:0]           cur_addr;
  logic [31:0]           cur_wdata;
  logic [3:0]            cur_byte_en;
  logic                  addr_error;
  logic [ADDR_WIDTH-1:0] word_index;

  assign req_ready = (state == IDLE) && reset_n;
  assign stall     = (state == WAIT) || ((state == IDLE) && req_valid);
  assign accept    = req_valid && req_ready;

  // With LATENCY 1 the access happens on the accepting edge itself, so the
  // request is taken straight from the inputs; otherwise from the latched copy.
  assign enter_resp = reset_n &&
                      ((SINGLE_CYCLE && accept) ||
                       ((state == WAIT) && (wait_cnt == 4'd0)));

  assign cur_write   = (state == IDLE) ? req_write   : lat_write;
  assign cur_addr    = (state == IDLE) ? req_addr    : lat_addr;
  assign cur_wdata   = (state == IDLE) ? req_wdata   : lat_wdata;
  assign cur_byte_en = (state == IDLE) ? req_byte_en : lat_byte_en;

  assign addr_error = (cur_addr[1:0] != 2'b00) ||
                      ((cur_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  assign word_index = cur_addr[ADDR_WIDTH+1:2];

  // Request sequencing, latency counting and the registered response outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wait_cnt    <= 4'd0;
      lat_write   <= 1'b0;
      lat_addr    <= 32'd0;
      lat_wdata   <= 32'd0;
      lat_byte_en <= 4'd0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'd0;
      rsp_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_write   <= req_write;
            lat_addr    <= req_addr;
            lat_wdata   <= req_wdata;
            lat_byte_en <= req_byte_en;
            if (SINGLE_CYCLE) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      rsp_valid <= enter_resp;
      if (enter_resp) begin
        rsp_error <= addr_error;
        rsp_rdata <= (addr_error || cur_write) ? 32'd0 : mem[word_index];
      end
    end
  end

  // Byte-lane store into the array; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (enter_resp && cur_write && !addr_error) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_byte_en[i]) begin
          mem[word_index][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for dmem_responder, with a
// LATENCY 2 instance for the main sequence and a LATENCY 1 instance alongside.
module tb_dmem_responder;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } exp_t;

  logic        clock;
  logic        reset_n;

  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_byte_en;
  logic        rsp_valid, rsp_error, stall;
  logic [31:0] rsp_rdata;

  logic        req_valid1, req_ready1, req_write1;
  logic [31:0] req_addr1, req_wdata1;
  logic [3:0]  req_byte_en1;
  logic        rsp_valid1, rsp_error1, stall1;
  logic [31:0] rsp_rdata1;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  exp_t        sb[$];
  logic [31:0] model_mem [int];

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .stall(stall)
  );

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_byte_en(req_byte_en1),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_error(rsp_error1),
    .stall(stall1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Waits for the response, pops the scoreboard and checks the pulse width.
  task automatic wait_response(input string tag, input int exp_edges);
    int   n;
    exp_t e;
    n = 0;
    e = '0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check_output({tag, "_latency"}, n, exp_edges);
    if (sb.size() > 0) e = sb.pop_front();
    check_output({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    check_output({tag, "_rdata"}, rsp_rdata, e.rdata);
    check_output({tag, "_error"}, {31'd0, rsp_error}, {31'd0, e.error});
    check_output({tag, "_stall_resp"}, {31'd0, stall}, 32'd0);
    tick();
    check_output({tag, "_pulse"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  // Predicts the response from the model, then drives one request to the LATENCY 2 instance.
  task automatic apply_stimulus(input string tag, input logic write, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be);
    exp_t        e;
    logic        err;
    int          idx;
    logic [31:0] w;
    err = (addr[1:0] != 2'b00) || (addr[31:12] != 20'd0);
    idx = int'(addr[11:2]);
    e.error = err;
    e.rdata = 32'd0;
    if (!err) begin
      if (write) begin
        w = model_mem.exists(idx) ? model_mem[idx] : 32'd0;
        for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
        model_mem[idx] = w;
      end else begin
        e.rdata = model_mem[idx];
      end
    end
    sb.push_back(e);

    req_valid = 1'b1;
    req_write = write;
    req_addr = addr;
    req_wdata = wdata;
    req_byte_en = be;
    #1;
    check_output({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
    check_output({tag, "_stall_req"}, {31'd0, stall}, 32'd1);
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    #1;
    check_output({tag, "_ready_wait"}, {31'd0, req_ready}, 32'd0);
    check_output({tag, "_stall_wait"}, {31'd0, stall}, 32'd1);
    check_output({tag, "_valid_wait"}, {31'd0, rsp_valid}, 32'd0);
    wait_response(tag, 1);
  endtask

  // One access on the LATENCY 1 instance: response must follow the accepting edge.
  task automatic l1_access(input string tag, input logic write, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata);
    req_valid1 = 1'b1;
    req_write1 = write;
    req_addr1 = addr;
    req_wdata1 = wdata;
    req_byte_en1 = 4'hF;
    #1;
    check_output({tag, "_stall_req"}, {31'd0, stall1}, 32'd1);
    check_output({tag, "_ready"}, {31'd0, req_ready1}, 32'd1);
    tick();
    req_valid1 = 1'b0;
    #1;
    check_output({tag, "_valid"}, {31'd0, rsp_valid1}, 32'd1);
    check_output({tag, "_stall_resp"}, {31'd0, stall1}, 32'd0);
    check_output({tag, "_rdata"}, rsp_rdata1, exp_rdata);
    check_output({tag, "_error"}, {31'd0, rsp_error1}, 32'd0);
    tick();
    check_output({tag, "_pulse"}, {31'd0, rsp_valid1}, 32'd0);
    check_output({tag, "_stall_idle"}, {31'd0, stall1}, 32'd0);
  endtask

  initial begin
    int t0;
    int k;
    exp_t e;

    reset_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_byte_en = '0;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = '0; req_wdata1 = '0; req_byte_en1 = '0;
    #12;
    check_output("reset_ready", {31'd0, req_ready}, 32'd0);
    check_output("reset_valid", {31'd0, rsp_valid}, 32'd0);
    check_output("reset_rdata", rsp_rdata, 32'd0);
    check_output("reset_error", {31'd0, rsp_error}, 32'd0);
    check_output("reset_stall", {31'd0, stall}, 32'd0);
    reset_n = 1'b1;
    tick();
    check_output("post_reset_ready", {31'd0, req_ready}, 32'd1);

    // Basic store/load and partial byte-lane store.
    apply_stimulus("st_10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    apply_stimulus("ld_10", 1'b0, 32'h10, 32'h0, 4'h0);
    apply_stimulus("st_10_b0", 1'b1, 32'h10, 32'h000000AA, 4'h1);
    apply_stimulus("ld_10_b0", 1'b0, 32'h10, 32'h0, 4'h0);

    // Known contents for later checks, including the top word of the array.
    apply_stimulus("st_0", 1'b1, 32'h0, 32'h11111111, 4'hF);
    apply_stimulus("st_4", 1'b1, 32'h4, 32'h22222222, 4'hF);
    apply_stimulus("st_ffc", 1'b1, 32'hFFC, 32'hCAFEF00D, 4'hF);
    apply_stimulus("ld_ffc", 1'b0, 32'hFFC, 32'h0, 4'h0);

    // Error cases and stores that must not change the array.
    apply_stimulus("ld_13", 1'b0, 32'h13, 32'h0, 4'h0);
    apply_stimulus("ld_1000", 1'b0, 32'h1000, 32'h0, 4'h0);
    apply_stimulus("st_2_mis", 1'b1, 32'h2, 32'hBADBAD00, 4'hF);
    apply_stimulus("st_1000_oor", 1'b1, 32'h1000, 32'hBADBAD11, 4'hF);
    apply_stimulus("st_0_be0", 1'b1, 32'h0, 32'h99999999, 4'h0);
    apply_stimulus("ld_0", 1'b0, 32'h0, 32'h0, 4'h0);

    // Back-to-back loads with req_valid held high.
    e.rdata = model_mem[0];
    e.error = 1'b0;
    sb.push_back(e);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 32'h0;
    #1;
    check_output("b2b_ready0", {31'd0, req_ready}, 32'd1);
    tick();
    t0 = cyc;
    req_addr = 32'h4;
    e.rdata = model_mem[1];
    sb.push_back(e);
    wait_response("b2b_first", 1);
    k = 0;
    while (!req_ready && k < 20) begin
      tick();
      k++;
    end
    tick();
    check_output("b2b_spacing", cyc - t0, 32'd3);
    req_valid = 1'b0;
    #1;
    wait_response("b2b_second", 1);

    // Reset during WAIT abandons a pending store.
    apply_stimulus("st_20", 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF);
    apply_stimulus("ld_20", 1'b0, 32'h20, 32'h0, 4'h0);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 32'h20;
    req_wdata = 32'h5A5A5A5A;
    req_byte_en = 4'hF;
    #1;
    tick();
    req_valid = 1'b0;
    req_write = 1'b0;
    #1;
    check_output("abort_in_wait", {31'd0, req_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    check_output("abort_ready", {31'd0, req_ready}, 32'd0);
    check_output("abort_stall", {31'd0, stall}, 32'd0);
    check_output("abort_valid", {31'd0, rsp_valid}, 32'd0);
    check_output("abort_rdata", rsp_rdata, 32'd0);
    check_output("abort_error", {31'd0, rsp_error}, 32'd0);
    tick();
    check_output("abort_valid_held", {31'd0, rsp_valid}, 32'd0);
    reset_n = 1'b1;
    #1;
    check_output("abort_ready_after", {31'd0, req_ready}, 32'd1);
    apply_stimulus("ld_20_after_abort", 1'b0, 32'h20, 32'h0, 4'h0);

    // LATENCY 1 instance.
    tick();
    l1_access("l1_st_8", 1'b1, 32'h8, 32'h12345678, 32'h0);
    l1_access("l1_ld_8", 1'b0, 32'h8, 32'h0, 32'h12345678);

    check_output("sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
